noc_packetizer: RTL and testbench
=================================

// Module: noc_packetizer
// PURPOSE
//  Network-interface TX stage placed directly upstream of a mesh router local port (NodeN_data_in/valid_in/ready_in).
//  Accepts a packet command (dest, length) and a stream of payload words from a core.
//  Emits a head/body/tail flit sequence in the NoC flit format.
//  Flit format: [31:30] type (01 head, 10 body, 11 tail); head payload = (NODE_ID << ID_WIDTH) | dest.
// PARAMETERS
//  DATA_WIDTH   32   flit width; payload word width is DATA_WIDTH-2
//  ID_WIDTH     4    width of the src and dest fields in the head flit
//  NODE_ID      0    source id inserted into every head flit
//  NUM_NODES    9    valid dest range is 0..NUM_NODES-1
//  LEN_WIDTH    5    width of cmd_len; max payload flits = 2**LEN_WIDTH-1
// PORTS
//  clk         in   1              clock, rising edge
//  rst         in   1              synchronous reset, active-low (rst==0 resets at posedge clk)
//  cmd_dest    in   ID_WIDTH       destination node
//  cmd_len     in   LEN_WIDTH      payload flit count (body+tail), 1..max
//  cmd_valid   in   1              command valid
//  cmd_ready   out  1              command accepted when cmd_valid&&cmd_ready
//  pld_data    in   DATA_WIDTH-2   payload word
//  pld_valid   in   1              payload valid
//  pld_ready   out  1              payload accepted when pld_valid&&pld_ready
//  flit_data   out  DATA_WIDTH     flit to router local input
//  flit_valid  out  1              flit valid
//  flit_ready  in   1              router ready; a flit transfers when flit_valid&&flit_ready
//  busy        out  1              high when state!=IDLE or flit_valid
//  err_cmd     out  1              one-cycle pulse: command dropped (len==0 or dest>=NUM_NODES)
//  pkt_count   out  16             count of tail flits transferred; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset outputs: flit_valid=0, flit_data=0, err_cmd=0, pkt_count=0, busy=0, state=IDLE.
//  Reset also clears the remaining-flit counter. Reset mid-packet truncates the packet (no tail is sent).
//  Output register rules:
//   - Single registered flit slot. It loads when !flit_valid || flit_ready ("slot_free").
//   - flit_valid, once high, stays high with stable flit_data until it transfers.
//  FSM states: IDLE, PAYLOAD.
//  IDLE:
//   - cmd_ready = slot_free.
//   - On a cmd handshake with a legal cmd: load the head flit, rem=cmd_len, go to PAYLOAD.
//     The head is valid on the next cycle (1-cycle latency).
//   - On a cmd handshake with an illegal cmd: err_cmd=1 for 1 cycle, stay in IDLE, no flit is emitted.
//   - pld_ready=0.
//  PAYLOAD:
//   - cmd_ready=0. pld_ready = slot_free.
//   - On a pld handshake: load {type, pld_data} and decrement rem.
//     type=10 if rem>1, or type=11 if rem==1; when rem==1 return to IDLE.
//  Throughput and latency:
//   - One flit per cycle when flit_ready is held high.
//   - Back-to-back packets add no bubble: a cmd is accepted in the same cycle the tail transfers.
//  Head flit fields:
//   - [31:30]=01, [2*ID_WIDTH-1:ID_WIDTH]=NODE_ID, [ID_WIDTH-1:0]=cmd_dest.
//   - All other bits are 0.
//  Self-addressed packets (dest==NODE_ID) are legal and are emitted normally.
//  pkt_count increments on the tail-flit transfer, and only then.
// TESTING
//  1 Reset (rst=0 for 2 cycles), then idle.
//    -> All outputs 0; cmd_ready=1; pld_ready=0.
//  2 NODE_ID=0, cmd dest=7 len=5, payload 0x12..0x16, flit_ready=1.
//    -> Flits 0x40000007, 0x80000012..0x80000015, 0xC0000016 on consecutive cycles; pkt_count=1.
//  3 Same packet with flit_ready toggled 1,0,1,0.
//    -> Each flit is held stable while stalled; no flit is lost or duplicated; pld_ready=0 while the slot is full.
//  4 cmd len=0, then cmd dest=9.
//    -> err_cmd pulses once per command; no flit_valid; state stays IDLE.
//  5 Two back-to-back cmds (dest 7 len 5, dest 5 len 5), flit_ready=1.
//    -> 12 contiguous flits with no bubble; pkt_count=2.
//  6 rst=0 after the 3rd flit of a packet.
//    -> Next cycle flit_valid=0; state IDLE; a new cmd is accepted and its packet is correct.

Source files
------------

// File: rtl/noc_packetizer.sv
// NoC network-interface TX stage: turns a (dest, len) command plus a payload
// word stream into head/body/tail flits through a single registered output slot.
module noc_packetizer #(
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int NODE_ID    = 0,
    parameter int NUM_NODES  = 9,
    parameter int LEN_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   cmd_dest,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-3:0] pld_data,
    input  logic                  pld_valid,
    output logic                  pld_ready,
    output logic [DATA_WIDTH-1:0] flit_data,
    output logic                  flit_valid,
    input  logic                  flit_ready,
    output logic                  busy,
    output logic                  err_cmd,
    output logic [15:0]           pkt_count
);

    typedef enum logic {IDLE, PAYLOAD} state_t;

    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_BODY = 2'b10;
    localparam logic [1:0] TYPE_TAIL = 2'b11;
    localparam int HEAD_PAD = DATA_WIDTH - 2 - 2 * ID_WIDTH;
    localparam logic [ID_WIDTH:0]   NUM_NODES_W = (ID_WIDTH + 1)'(NUM_NODES);
    localparam logic [ID_WIDTH-1:0] NODE_ID_W   = ID_WIDTH'(NODE_ID);

    state_t                state_reg, state_next;
    logic [LEN_WIDTH-1:0]  rem_reg, rem_next;
    logic [DATA_WIDTH-1:0] flit_data_reg, flit_data_next;
    logic                  flit_valid_reg, flit_valid_next;
    logic                  err_cmd_reg, err_cmd_next;
    logic [15:0]           pkt_count_reg;

    logic                  slot_free;
    logic                  cmd_legal;
    logic                  tail_xfer;
    logic [DATA_WIDTH-1:0] head_flit;

    assign slot_free = !flit_valid_reg || flit_ready;
    assign cmd_legal = (cmd_len != '0) && ({1'b0, cmd_dest} < NUM_NODES_W);
    assign head_flit = {TYPE_HEAD, {HEAD_PAD{1'b0}}, NODE_ID_W, cmd_dest};
    assign tail_xfer = flit_valid_reg && flit_ready
                       && (flit_data_reg[DATA_WIDTH-1:DATA_WIDTH-2] == TYPE_TAIL);

    always_comb begin
        state_next      = state_reg;
        rem_next        = rem_reg;
        flit_data_next  = flit_data_reg;
        // A flit that transfers without a replacement leaves the slot empty.
        flit_valid_next = flit_valid_reg && !flit_ready;
        err_cmd_next    = 1'b0;
        cmd_ready       = 1'b0;
        pld_ready       = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready = slot_free;
                if (cmd_valid && slot_free) begin
                    if (cmd_legal) begin
                        flit_data_next  = head_flit;
                        flit_valid_next = 1'b1;
                        rem_next        = cmd_len;
                        state_next      = PAYLOAD;
                    end else begin
                        err_cmd_next = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                pld_ready = slot_free;
                if (pld_valid && slot_free) begin
                    flit_valid_next = 1'b1;
                    rem_next        = rem_reg - 1'b1;
                    if (rem_reg == LEN_WIDTH'(1)) begin
                        flit_data_next = {TYPE_TAIL, pld_data};
                        state_next     = IDLE;
                    end else begin
                        flit_data_next = {TYPE_BODY, pld_data};
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            rem_reg        <= '0;
            flit_data_reg  <= '0;
            flit_valid_reg <= 1'b0;
            err_cmd_reg    <= 1'b0;
            pkt_count_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            rem_reg        <= rem_next;
            flit_data_reg  <= flit_data_next;
            flit_valid_reg <= flit_valid_next;
            err_cmd_reg    <= err_cmd_next;
            if (tail_xfer) begin
                pkt_count_reg <= pkt_count_reg + 16'd1;
            end
        end
    end

    assign flit_data  = flit_data_reg;
    assign flit_valid = flit_valid_reg;
    assign err_cmd    = err_cmd_reg;
    assign pkt_count  = pkt_count_reg;
    assign busy       = (state_reg != IDLE) || flit_valid_reg;

endmodule

// File: tb/tb_noc_packetizer.sv
// Directed bench for noc_packetizer: stimulus queues feed cmd/payload, a
// scoreboard of expected flits is filled on input handshakes and drained on flit transfers.
module tb_noc_packetizer;

    logic        clk;
    logic        rst;
    logic [3:0]  cmd_dest;
    logic [4:0]  cmd_len;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [29:0] pld_data;
    logic        pld_valid;
    logic        pld_ready;
    logic [31:0] flit_data;
    logic        flit_valid;
    logic        flit_ready;
    logic        busy;
    logic        err_cmd;
    logic [15:0] pkt_count;

    noc_packetizer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_dest   (cmd_dest),
        .cmd_len    (cmd_len),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .pld_data   (pld_data),
        .pld_valid  (pld_valid),
        .pld_ready  (pld_ready),
        .flit_data  (flit_data),
        .flit_valid (flit_valid),
        .flit_ready (flit_ready),
        .busy       (busy),
        .err_cmd    (err_cmd),
        .pkt_count  (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] dest;
        logic [4:0] len;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [29:0] pld_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] seen_q[$];

    int          total = 0;
    int          bad = 0;
    int          rem_m = 0;
    int          model_pkts = 0;
    int          cyc = 0;
    int          xfer_cnt = 0;
    int          err_seen = 0;
    int          first_x = -1;
    int          last_x = -1;
    logic        err_exp = 1'b0;
    logic        held_valid = 1'b0;
    logic [31:0] held = '0;
    bit          toggle_mode = 1'b0;
    bit          fr_phase = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        cmd_valid = (cmd_q.size() != 0);
        cmd_dest  = cmd_valid ? cmd_q[0].dest : 4'd0;
        cmd_len   = cmd_valid ? cmd_q[0].len : 5'd0;
        pld_valid = (pld_q.size() != 0);
        pld_data  = pld_valid ? pld_q[0] : 30'd0;
        flit_ready = toggle_mode ? fr_phase : 1'b1;
        fr_phase   = !fr_phase;
    endtask

    // One clock: drive, sample on the falling edge, update the scoreboard.
    task automatic step();
        cmd_t        c;
        logic [29:0] w;
        logic [31:0] e;
        drive();
        @(negedge clk);
        cyc++;
        if (rst) begin
            chk("pkt_count", {16'd0, pkt_count}, model_pkts);
            chk("err_cmd", {31'd0, err_cmd}, {31'd0, err_exp});
            if (err_cmd) err_seen++;
            if (held_valid) begin
                chk("stall_valid", {31'd0, flit_valid}, 32'd1);
                chk("stall_data", flit_data, held);
            end
            if (flit_valid && !flit_ready) begin
                chk("pld_ready_full", {31'd0, pld_ready}, 32'd0);
            end
            err_exp = 1'b0;
            if (cmd_valid && cmd_ready) begin
                c = cmd_q.pop_front();
                if (c.len != 5'd0 && c.dest < 4'd9) begin
                    exp_q.push_back({2'b01, 22'd0, 4'd0, c.dest});
                    rem_m = c.len;
                end else begin
                    err_exp = 1'b1;
                end
            end
            if (pld_valid && pld_ready) begin
                w = pld_q.pop_front();
                exp_q.push_back({(rem_m > 1) ? 2'b10 : 2'b11, w});
                rem_m--;
            end
            if (flit_valid && flit_ready) begin
                $display("flit %0d cycle %0d data=%h", xfer_cnt, cyc, flit_data);
                chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("flit", flit_data, e);
                    if (e[31:30] == 2'b11) model_pkts++;
                end
                seen_q.push_back(flit_data);
                xfer_cnt++;
                if (first_x < 0) first_x = cyc;
                last_x = cyc;
            end
            held_valid = flit_valid && !flit_ready;
            held       = flit_data;
        end else begin
            exp_q.delete();
            rem_m      = 0;
            model_pkts = 0;
            err_exp    = 1'b0;
            held_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int maxc);
        int  n;
        logic done;
        n = 0;
        done = 1'b0;
        while (!done && n < maxc) begin
            step();
            n++;
            done = (cmd_q.size() == 0) && (pld_q.size() == 0) && (exp_q.size() == 0) && !busy;
        end
        chk("run_done", {31'd0, done}, 32'd1);
        step();
        step();
    endtask

    task automatic new_test();
        seen_q.delete();
        first_x = -1;
        last_x  = -1;
    endtask

    initial begin
        int base;
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_dest = '0; cmd_len = '0;
        pld_valid = 1'b0; pld_data = '0; flit_ready = 1'b1;
        @(posedge clk);
        #1;

        // Reset for two cycles, then idle.
        step();
        step();
        rst = 1'b1;
        step();
        chk("rst_flit_valid", {31'd0, flit_valid}, 32'd0);
        chk("rst_flit_data", flit_data, 32'd0);
        chk("rst_err_cmd", {31'd0, err_cmd}, 32'd0);
        chk("rst_pkt_count", {16'd0, pkt_count}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_pld_ready", {31'd0, pld_ready}, 32'd0);

        // Single packet, router always ready.
        new_test();
        cmd_q.push_back('{dest: 4'd7, len: 5'd5});
        for (int i = 0; i < 5; i++) pld_q.push_back(30'h12 + 30'(i));
        run(40);
        chk("t2_count", seen_q.size(), 32'd6);
        chk("t2_head", seen_q[0], 32'h4000_0007);
        chk("t2_body0", seen_q[1], 32'h8000_0012);
        chk("t2_tail", seen_q[5], 32'hC000_0016);
        chk("t2_span", last_x - first_x, 32'd5);
        chk("t2_pkts", {16'd0, pkt_count}, 32'd1);

        // Same packet with the router stalling every other cycle.
        new_test();
        toggle_mode = 1'b1;
        fr_phase    = 1'b1;
        cmd_q.push_back('{dest: 4'd7, len: 5'd5});
        for (int i = 0; i < 5; i++) pld_q.push_back(30'h12 + 30'(i));
        run(80);
        toggle_mode = 1'b0;
        chk("t3_count", seen_q.size(), 32'd6);
        chk("t3_head", seen_q[0], 32'h4000_0007);
        chk("t3_tail", seen_q[5], 32'hC000_0016);
        chk("t3_pkts", {16'd0, pkt_count}, 32'd2);

        // Illegal commands: zero length and out-of-range destinations.
        new_test();
        err_seen = 0;
        base = xfer_cnt;
        cmd_q.push_back('{dest: 4'd3, len: 5'd0});
        cmd_q.push_back('{dest: 4'd9, len: 5'd3});
        cmd_q.push_back('{dest: 4'd15, len: 5'd2});
        run(20);
        chk("t4_err_pulses", err_seen, 32'd3);
        chk("t4_no_flits", xfer_cnt - base, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);

        // Back-to-back packets, no bubble between tail and next head.
        new_test();
        cmd_q.push_back('{dest: 4'd7, len: 5'd5});
        cmd_q.push_back('{dest: 4'd5, len: 5'd5});
        for (int i = 0; i < 5; i++) pld_q.push_back(30'h20 + 30'(i));
        for (int i = 0; i < 5; i++) pld_q.push_back(30'h30 + 30'(i));
        run(60);
        chk("t5_count", seen_q.size(), 32'd12);
        chk("t5_span", last_x - first_x, 32'd11);
        chk("t5_head2", seen_q[6], 32'h4000_0005);
        chk("t5_tail2", seen_q[11], 32'hC000_0034);
        chk("t5_pkts", {16'd0, pkt_count}, 32'd4);

        // Reset in the middle of a packet, then a fresh packet.
        new_test();
        base = xfer_cnt;
        cmd_q.push_back('{dest: 4'd2, len: 5'd6});
        for (int i = 0; i < 6; i++) pld_q.push_back(30'h40 + 30'(i));
        for (int i = 0; i < 30 && (xfer_cnt - base) < 3; i++) step();
        chk("t6_reached3", xfer_cnt - base, 32'd3);
        cmd_q.delete();
        pld_q.delete();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("t6_flit_valid", {31'd0, flit_valid}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        new_test();
        cmd_q.push_back('{dest: 4'd4, len: 5'd2});
        pld_q.push_back(30'h50);
        pld_q.push_back(30'h51);
        run(30);
        chk("t6_count", seen_q.size(), 32'd3);
        chk("t6_head", seen_q[0], 32'h4000_0004);
        chk("t6_tail", seen_q[2], 32'hC000_0051);
        chk("t6_pkts", {16'd0, pkt_count}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
